// File: rtl/planificador_lectura_rtc.sv
// Schedules the RTC register bus. Each vertical-blank entry triggers a read of
// all displayed registers into a staging buffer, which is then published to the
// display path in one cycle. User programming writes take the bus ahead of any
// pending snapshot reads.
module planificador_lectura_rtc #(
    parameter int unsigned N_REGS     = 11,
    parameter int unsigned V_ACTIVE   = 480,
    parameter logic [7:0]  ADDR_RELOJ = 8'h21,
    parameter logic [7:0]  ADDR_TIMER = 8'h41,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            pixely,
    input  logic                  wr_req,
    input  logic [7:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wr_ack,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [7:0]            bus_addr,
    output logic [7:0]            bus_wdata,
    input  logic [7:0]            bus_rdata,
    input  logic                  bus_ack,
    output logic [8*N_REGS-1:0]   datos_o,
    output logic                  snap_valid,
    output logic                  frame_miss,
    output logic                  bus_err,
    output logic                  busy
);

    localparam int unsigned IDX_W = $clog2(N_REGS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned DAT_W = 8 * N_REGS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);

    typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, GAP, PUBLISH} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               seq_act, seq_act_nxt;
    logic               start_pend, start_pend_nxt;
    logic               blank_q, armed;
    logic [DAT_W-1:0]   staging, staging_nxt;
    logic [DAT_W-1:0]   datos_nxt;
    logic               bus_req_nxt, bus_we_nxt;
    logic [7:0]         bus_addr_nxt, bus_wdata_nxt;
    logic               wr_ack_nxt, snap_nxt, miss_nxt, bus_err_nxt, busy_nxt;
    logic               blank_now, rise;

    // Blank edge is ignored in the first cycle after reset so an already-active
    // blank does not start a snapshot.
    assign blank_now = (pixely >= V_ACT);
    assign rise      = armed & blank_now & ~blank_q;

    // Snapshot index to RTC bus address.
    function automatic logic [7:0] map_addr(input logic [IDX_W-1:0] i);
        if (i < IDX_W'(8)) return ADDR_RELOJ + 8'(i);
        else               return ADDR_TIMER + 8'(i - IDX_W'(8));
    endfunction

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            seq_act    <= 1'b0;
            start_pend <= 1'b0;
            blank_q    <= 1'b0;
            armed      <= 1'b0;
            staging    <= '0;
            datos_o    <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            wr_ack     <= 1'b0;
            snap_valid <= 1'b0;
            frame_miss <= 1'b0;
            bus_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            seq_act    <= seq_act_nxt;
            start_pend <= start_pend_nxt;
            blank_q    <= blank_now;
            armed      <= 1'b1;
            staging    <= staging_nxt;
            datos_o    <= datos_nxt;
            bus_req    <= bus_req_nxt;
            bus_we     <= bus_we_nxt;
            bus_addr   <= bus_addr_nxt;
            bus_wdata  <= bus_wdata_nxt;
            wr_ack     <= wr_ack_nxt;
            snap_valid <= snap_nxt;
            frame_miss <= miss_nxt;
            bus_err    <= bus_err_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state and next-output decisions.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cnt_nxt        = cnt;
        seq_act_nxt    = seq_act;
        start_pend_nxt = start_pend | rise;
        staging_nxt    = staging;
        datos_nxt      = datos_o;
        bus_req_nxt    = bus_req;
        bus_we_nxt     = bus_we;
        bus_addr_nxt   = bus_addr;
        bus_wdata_nxt  = bus_wdata;
        wr_ack_nxt     = 1'b0;
        snap_nxt       = 1'b0;
        miss_nxt       = 1'b0;
        bus_err_nxt    = bus_err;

        unique case (state)
            IDLE: begin
                if (wr_req) begin
                    state_nxt     = WR_REQ;
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = 1'b1;
                    bus_addr_nxt  = wr_addr;
                    bus_wdata_nxt = wr_data;
                    cnt_nxt       = '0;
                end else if (start_pend) begin
                    start_pend_nxt = rise;
                    idx_nxt        = '0;
                    seq_act_nxt    = 1'b1;
                    state_nxt      = RD_REQ;
                    bus_req_nxt    = 1'b1;
                    bus_we_nxt     = 1'b0;
                    bus_addr_nxt   = map_addr('0);
                    cnt_nxt        = '0;
                end
            end
            RD_REQ: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (bus_ack) begin
                    staging_nxt[int'(idx)*8 +: 8] = bus_rdata;
                    bus_req_nxt = 1'b0;
                    state_nxt   = GAP;
                end else if (cnt == CNT_LAST) begin
                    bus_req_nxt = 1'b0;
                    bus_err_nxt = 1'b1;
                    miss_nxt    = 1'b1;
                    seq_act_nxt = 1'b0;
                    staging_nxt = '0;
                    state_nxt   = GAP;
                end
            end
            WR_REQ: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (bus_ack) begin
                    wr_ack_nxt  = 1'b1;
                    bus_req_nxt = 1'b0;
                    state_nxt   = GAP;
                end else if (cnt == CNT_LAST) begin
                    wr_ack_nxt  = 1'b1;
                    bus_err_nxt = 1'b1;
                    bus_req_nxt = 1'b0;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                // wr_req seen together with wr_ack is the write just finished.
                if (wr_req && !wr_ack) begin
                    state_nxt     = WR_REQ;
                    bus_req_nxt   = 1'b1;
                    bus_we_nxt    = 1'b1;
                    bus_addr_nxt  = wr_addr;
                    bus_wdata_nxt = wr_data;
                    cnt_nxt       = '0;
                end else if (seq_act && (idx < LAST_IDX)) begin
                    if (!blank_q) begin
                        miss_nxt    = 1'b1;
                        seq_act_nxt = 1'b0;
                        staging_nxt = '0;
                        state_nxt   = IDLE;
                    end else begin
                        idx_nxt      = idx + IDX_W'(1);
                        state_nxt    = RD_REQ;
                        bus_req_nxt  = 1'b1;
                        bus_we_nxt   = 1'b0;
                        bus_addr_nxt = map_addr(idx + IDX_W'(1));
                        cnt_nxt      = '0;
                    end
                end else if (seq_act) begin
                    datos_nxt   = staging;
                    snap_nxt    = 1'b1;
                    seq_act_nxt = 1'b0;
                    state_nxt   = PUBLISH;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_planificador_lectura_rtc.sv
// Scoreboard bench for planificador_lectura_rtc: stimulus queues expected bus
// transactions and pulses; a monitor pops and compares as the DUT produces them.
module tb_planificador_lectura_rtc;

    localparam int K_BUS   = 0;
    localparam int K_SNAP  = 1;
    localparam int K_MISS  = 2;
    localparam int K_WRACK = 3;

    typedef struct {
        int          kind;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [87:0] datos;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [9:0]  pixely;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic        bus_req;
    logic        bus_we;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;
    logic [87:0] datos_o;
    logic        snap_valid;
    logic        frame_miss;
    logic        bus_err;
    logic        busy;

    ev_t         sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        ack_en;
    int          ack_delay;
    logic [7:0]  rd_base;
    logic [7:0]  addr_tab [0:10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                     8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

    planificador_lectura_rtc dut (
        .clk        (clk),
        .reset      (reset),
        .pixely     (pixely),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .datos_o    (datos_o),
        .snap_valid (snap_valid),
        .frame_miss (frame_miss),
        .bus_err    (bus_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [87:0] snap_of(input logic [7:0] b);
        logic [87:0] d;
        d = '0;
        for (int i = 0; i < 11; i++) d[8*i +: 8] = b + 8'(i);
        return d;
    endfunction

    function automatic logic [7:0] idx_of(input logic [7:0] a);
        if (a >= 8'h41) return a - 8'h41 + 8'd8;
        else            return a - 8'h21;
    endfunction

    task automatic push_reads(input int first, input int last);
        ev_t e;
        for (int i = first; i <= last; i++) begin
            e = '{kind: K_BUS, we: 1'b0, addr: addr_tab[i], wdata: 8'h00, datos: '0};
            sb.push_back(e);
        end
    endtask

    task automatic push_ev(input int kind, input logic we, input logic [7:0] a,
                           input logic [7:0] wd, input logic [87:0] d);
        ev_t e;
        e = '{kind: kind, we: we, addr: a, wdata: wd, datos: d};
        sb.push_back(e);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: kind %0d seen, scoreboard empty", kind);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 128'(kind), 128'(e.kind));
            if (kind == K_BUS) begin
                chk("bus_we", 128'(bus_we), 128'(e.we));
                chk("bus_addr", 128'(bus_addr), 128'(e.addr));
                if (e.we) chk("bus_wdata", 128'(bus_wdata), 128'(e.wdata));
            end else if (kind == K_SNAP) begin
                chk("datos_o_publish", 128'(datos_o), 128'(e.datos));
            end
        end
    endtask

    // Monitor: every DUT event pops one scoreboard entry.
    initial begin
        logic        prev_req;
        logic [87:0] prev_datos;
        prev_req   = 1'b0;
        prev_datos = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus_req && !prev_req) take(K_BUS);
                if (snap_valid)           take(K_SNAP);
                if (frame_miss)           take(K_MISS);
                if (wr_ack)               take(K_WRACK);
                if (datos_o != prev_datos) chk("datos_change_with_snap", 128'(snap_valid), 128'(1));
            end
            prev_req   = bus_req;
            prev_datos = datos_o;
        end
    end

    // RTC bus model: acks ack_delay cycles after a request appears.
    initial begin
        logic [7:0] last;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_req && ack_en && reset) begin
                repeat (ack_delay) @(negedge clk);
                bus_rdata = rd_base + idx_of(bus_addr);
                last      = bus_addr;
                bus_ack   = 1'b1;
                @(negedge clk);
                bus_ack   = 1'b0;
                if (last == 8'h43) rd_base = rd_base + 8'h20;
            end
        end
    end

    task automatic wait_req_addr(input logic [7:0] a, input int budget);
        int n = 0;
        while (!(bus_req && bus_addr == a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_req_addr", 128'(bus_req && bus_addr == a), 128'(1));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 128'(sb.size()), 128'(0));
    endtask

    task automatic check_zero(input string p);
        chk({p, "_wr_ack"},     128'(wr_ack),     128'(0));
        chk({p, "_bus_req"},    128'(bus_req),    128'(0));
        chk({p, "_bus_we"},     128'(bus_we),     128'(0));
        chk({p, "_bus_addr"},   128'(bus_addr),   128'(0));
        chk({p, "_bus_wdata"},  128'(bus_wdata),  128'(0));
        chk({p, "_datos_o"},    128'(datos_o),    128'(0));
        chk({p, "_snap_valid"}, 128'(snap_valid), 128'(0));
        chk({p, "_frame_miss"}, 128'(frame_miss), 128'(0));
        chk({p, "_bus_err"},    128'(bus_err),    128'(0));
        chk({p, "_busy"},       128'(busy),       128'(0));
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        pixely    = 10'd0;
        wr_req    = 1'b0;
        wr_addr   = 8'h00;
        wr_data   = 8'h00;
        ack_en    = 1'b1;
        ack_delay = 2;
        rd_base   = 8'h10;
        repeat (3) @(negedge clk);
        check_zero("reset");

        // Blank already active when reset releases: no snapshot.
        pixely = 10'd500;
        reset  = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_start_from_reset_busy", 128'(busy), 128'(0));
        pixely = 10'd0;
        repeat (3) @(negedge clk);

        // Plain snapshot, 479 -> 480, L=2.
        push_reads(0, 10);
        push_ev(K_SNAP, 1'b0, 8'h00, 8'h00, snap_of(8'h10));
        pixely = 10'd479;
        @(negedge clk);
        pixely = 10'd480;
        @(negedge clk);
        chk("latency_cycle1_req", 128'(bus_req), 128'(0));
        @(negedge clk);
        chk("latency_cycle2_req", 128'(bus_req), 128'(1));
        wait_drain("snapshot_plain_done", 300);
        repeat (3) @(negedge clk);
        chk("idle_after_snapshot", 128'(busy), 128'(0));
        pixely = 10'd0;
        repeat (3) @(negedge clk);

        // Programming write inserted during read index 3.
        rd_base = 8'h30;
        push_reads(0, 3);
        push_ev(K_BUS, 1'b1, 8'h22, 8'h45, '0);
        push_ev(K_WRACK, 1'b0, 8'h00, 8'h00, '0);
        push_reads(4, 10);
        push_ev(K_SNAP, 1'b0, 8'h00, 8'h00, snap_of(8'h30));
        pixely = 10'd480;
        wait_req_addr(8'h24, 100);
        wr_addr = 8'h22;
        wr_data = 8'h45;
        wr_req  = 1'b1;
        n = 0;
        while (!wr_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wr_ack_seen", 128'(wr_ack), 128'(1));
        wr_req = 1'b0;
        wait_drain("snapshot_with_write_done", 300);
        pixely = 10'd0;
        repeat (5) @(negedge clk);

        // Blank ends while reading index 6: abort.
        rd_base = 8'h50;
        push_reads(0, 6);
        push_ev(K_MISS, 1'b0, 8'h00, 8'h00, '0);
        pixely = 10'd480;
        wait_req_addr(8'h27, 100);
        pixely = 10'd0;
        wait_drain("abort_done", 100);
        repeat (5) @(negedge clk);
        chk("datos_kept_after_abort", 128'(datos_o), 128'(snap_of(8'h30)));
        chk("idle_after_abort", 128'(busy), 128'(0));

        // Bus never acks read 0: timeout.
        ack_en = 1'b0;
        push_reads(0, 0);
        push_ev(K_MISS, 1'b0, 8'h00, 8'h00, '0);
        pixely = 10'd480;
        wait_req_addr(8'h21, 10);
        n = 0;
        while (bus_req && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_req_cycles", 128'(n), 128'(255));
        wait_drain("timeout_miss_done", 20);
        chk("bus_err_set", 128'(bus_err), 128'(1));
        ack_en = 1'b1;
        pixely = 10'd0;
        repeat (5) @(negedge clk);

        // Two extra blank edges during one sequence: exactly one more sequence.
        rd_base = 8'h70;
        push_reads(0, 10);
        push_ev(K_SNAP, 1'b0, 8'h00, 8'h00, snap_of(8'h70));
        push_reads(0, 10);
        push_ev(K_SNAP, 1'b0, 8'h00, 8'h00, snap_of(8'h90));
        pixely = 10'd480;
        wait_req_addr(8'h23, 100);
        pixely = 10'd0;
        @(negedge clk);
        pixely = 10'd480;
        wait_req_addr(8'h26, 100);
        pixely = 10'd0;
        @(negedge clk);
        pixely = 10'd480;
        wait_drain("double_edge_done", 400);
        repeat (60) @(negedge clk);
        chk("idle_after_double", 128'(busy), 128'(0));
        chk("bus_err_sticky", 128'(bus_err), 128'(1));

        // Reset in the middle of read index 5.
        pixely = 10'd0;
        repeat (3) @(negedge clk);
        rd_base = 8'h10;
        push_reads(0, 5);
        pixely = 10'd480;
        wait_req_addr(8'h26, 100);
        #1 reset = 1'b0;
        #1 check_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_reset_no_req", 128'(bus_req), 128'(0));
        chk("post_reset_idle", 128'(busy), 128'(0));
        chk("post_reset_sb_empty", 128'(sb.size()), 128'(0));

        // Normal operation resumes on the next blank edge.
        rd_base = 8'h20;
        push_reads(0, 10);
        push_ev(K_SNAP, 1'b0, 8'h00, 8'h00, snap_of(8'h20));
        pixely = 10'd0;
        repeat (2) @(negedge clk);
        pixely = 10'd480;
        wait_drain("recovery_snapshot_done", 300);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
